// File: rtl/enemy_fleet_controller.sv
// Wave controller for the enemy fleet: spawn hold, lateral march with edge
// bounce and step-down, kill-driven speed-up, wave clear and game-over.
module enemy_fleet_controller #(
  parameter int NUM_ENEMIES  = 8,
  parameter int BASE_SPEED   = 64,
  parameter int SPEED_STEP   = 16,
  parameter int MAX_SPEED    = 256,
  parameter int SPAWN_FRAMES = 60,
  parameter int CLEAR_FRAMES = 90
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic                    hitValid,
  input  logic [3:0]              hitIndex,
  input  logic                    leftEdge,
  input  logic                    rightEdge,
  input  logic                    bottomReached,
  output logic [NUM_ENEMIES-1:0]  aliveMask,
  output logic signed [10:0]      xSpeed,
  output logic                    stepDown,
  output logic                    moveEnable,
  output logic [3:0]              waveNum,
  output logic                    gameOver
);

  typedef enum logic [1:0] {SPAWN, RUN, CLEARED, OVER} state_t;

  state_t                 state, state_nx;
  logic [NUM_ENEMIES-1:0] alive_nx;
  logic                   dir_left, dir_left_nx;
  logic [10:0]            speed, speed_nx;
  logic [4:0]             kills, kills_nx;
  logic [15:0]            frame_cnt, frame_cnt_nx;
  logic [3:0]             wave_nx;
  logic                   step_nx;
  logic [15:0]            mask16, hit_bit;
  logic                   hit_ok;

  function automatic logic [10:0] speed_for(input logic [4:0] k);
    int s;
    s = BASE_SPEED + SPEED_STEP * int'(k);
    if (s > MAX_SPEED) s = MAX_SPEED;
    return 11'(s);
  endfunction

  // Widen the mask to the full 4-bit index range so out-of-range slots read as dead.
  assign mask16  = 16'(aliveMask);
  assign hit_bit = 16'(1) << hitIndex;
  assign hit_ok  = hitValid && (int'(hitIndex) < NUM_ENEMIES) && mask16[hitIndex];

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_nx     = state;
    alive_nx     = aliveMask;
    dir_left_nx  = dir_left;
    speed_nx     = speed;
    kills_nx     = kills;
    frame_cnt_nx = frame_cnt;
    wave_nx      = waveNum;
    step_nx      = 1'b0;

    unique case (state)
      SPAWN: begin
        if (startOfFrame) begin
          if (frame_cnt == 16'(SPAWN_FRAMES - 1)) begin
            state_nx     = RUN;
            frame_cnt_nx = '0;
          end else begin
            frame_cnt_nx = frame_cnt + 16'd1;
          end
        end
      end

      RUN: begin
        if (startOfFrame && bottomReached) begin
          state_nx = OVER;
        end else begin
          if (hit_ok) begin
            alive_nx = aliveMask & ~hit_bit[NUM_ENEMIES-1:0];
            kills_nx = kills + 5'd1;
            speed_nx = speed_for(kills_nx);
          end
          if (startOfFrame && ((!dir_left && rightEdge) || (dir_left && leftEdge))) begin
            dir_left_nx = ~dir_left;
            step_nx     = 1'b1;
          end
          // The last kill ends the wave; a coincident bounce no longer steps down.
          if (alive_nx == '0) begin
            state_nx = CLEARED;
            step_nx  = 1'b0;
          end
        end
      end

      CLEARED: begin
        if (startOfFrame) begin
          if (frame_cnt == 16'(CLEAR_FRAMES - 1)) begin
            state_nx     = SPAWN;
            frame_cnt_nx = '0;
            wave_nx      = waveNum + 4'd1;
            alive_nx     = '1;
            dir_left_nx  = 1'b0;
            speed_nx     = 11'(BASE_SPEED);
            kills_nx     = '0;
          end else begin
            frame_cnt_nx = frame_cnt + 16'd1;
          end
        end
      end

      OVER: ;

      default: state_nx = SPAWN;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= SPAWN;
      aliveMask <= '1;
      dir_left  <= 1'b0;
      speed     <= 11'(BASE_SPEED);
      kills     <= '0;
      frame_cnt <= '0;
      waveNum   <= '0;
      stepDown  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state     <= state_nx;
      aliveMask <= alive_nx;
      dir_left  <= dir_left_nx;
      speed     <= speed_nx;
      kills     <= kills_nx;
      frame_cnt <= frame_cnt_nx;
      waveNum   <= wave_nx;
      stepDown  <= step_nx;
    end
  end

  assign moveEnable = (state == RUN);
  assign gameOver   = (state == OVER);

  always_comb begin
    xSpeed = '0;
    if (state == RUN) xSpeed = dir_left ? -$signed(speed) : $signed(speed);
  end

endmodule

// File: doc/enemy_fleet_controller.md
ENEMY_FLEET_CONTROLLER -- requirements
Module: enemy_fleet_controller

Interface
REQ-001 Parameter NUM_ENEMIES, default 8, enemy slots in a wave (max 16).
REQ-002 Parameter BASE_SPEED, default 64, initial horizontal speed, fixed-point units per frame (×64 multiplier).
REQ-003 Parameter SPEED_STEP, default 16, speed increment per kill.
REQ-004 Parameter MAX_SPEED, default 256, speed saturation limit.
REQ-005 Parameter SPAWN_FRAMES, default 60, frames held in SPAWN before movement.
REQ-006 Parameter CLEAR_FRAMES, default 90, frames held in CLEARED before next wave.
REQ-007 clk  in  1  system clock.
REQ-008 resetN  in  1  asynchronous, active-low reset.
REQ-009 startOfFrame  in  1  one-clk pulse per video frame.
REQ-010 hitValid  in  1  one-clk pulse: enemy hit by player shot.
REQ-011 hitIndex  in  4  slot index of the hit enemy; valid with hitValid.
REQ-012 leftEdge  in  1  some live enemy at/left of screen left bound.
REQ-013 rightEdge  in  1  some live enemy at/right of screen right bound.
REQ-014 bottomReached  in  1  some live enemy reached player row.
REQ-015 aliveMask  out  NUM_ENEMIES  bit i = enemy i alive and drawable.
REQ-016 xSpeed  out  11 signed  per-frame X delta for all movers (fixed-point).
REQ-017 stepDown  out  1  one-clk pulse: movers shift down one row.
REQ-018 moveEnable  out  1  movers apply xSpeed on startOfFrame.
REQ-019 waveNum  out  4  current wave number.
REQ-020 gameOver  out  1  level, fleet reached bottom.

Function
REQ-021 FSM states SPAWN, RUN, CLEARED, OVER; all updates on posedge clk.
REQ-022 SPAWN: aliveMask all ones, moveEnable 0, direction right; frame counter increments per startOfFrame; at SPAWN_FRAMES counts -> RUN, counter cleared.
REQ-023 RUN: moveEnable 1; xSpeed = +speed when direction right, -speed when left.
REQ-024 speed = BASE_SPEED + SPEED_STEP × killsThisWave, saturating at MAX_SPEED; recomputed each wave, reset to BASE_SPEED on SPAWN entry.
REQ-025 RUN, startOfFrame with direction right and rightEdge: direction flips left, stepDown pulses in the same cycle the flip registers (one clk).
REQ-026 RUN, startOfFrame with direction left and leftEdge: direction flips right, stepDown pulses one clk.
REQ-027 Edge inputs sampled only on startOfFrame in RUN; ignored otherwise; edge matching current direction only (leftEdge while moving right ignored).
REQ-028 hitValid in RUN with aliveMask[hitIndex]=1: clear bit, killsThisWave+1; hit on dead slot or hitIndex ≥ NUM_ENEMIES ignored; hitValid outside RUN ignored.
REQ-029 hitValid coincident with startOfFrame: both processed same cycle; new speed takes effect the next frame.
REQ-030 aliveMask becomes zero in RUN -> CLEARED next cycle; moveEnable 0, stepDown held 0.
REQ-031 CLEARED: count CLEAR_FRAMES startOfFrame pulses, then waveNum+1 (wraps 15->0) and -> SPAWN.
REQ-032 RUN, startOfFrame with bottomReached -> OVER; OVER takes priority over CLEARED and over a direction flip in the same cycle.
REQ-033 OVER: gameOver 1, moveEnable 0, xSpeed 0, aliveMask frozen; terminal until reset.
REQ-034 xSpeed = 0 in every state other than RUN.

Reset
REQ-035 resetN low asynchronously forces: state SPAWN, aliveMask all ones, direction right, speed BASE_SPEED, counters 0, waveNum 0, stepDown 0, moveEnable 0, gameOver 0, xSpeed 0.
REQ-036 Reset mid-wave (any state) discards kills and frame counts; release resumes at SPAWN with wave 0.

Verification
REQ-037 Reset, 60 SOF pulses -> RUN, moveEnable 1, xSpeed +64, aliveMask 8'hFF.
REQ-038 RUN right, rightEdge with SOF -> xSpeed -64 next cycle, stepDown high exactly 1 clk; leftEdge with SOF while left -> +64, stepDown 1 clk.
REQ-039 Hits on slots 0..3, repeat hit slot 2, hitIndex 9 -> aliveMask 8'hF0, xSpeed magnitude 128; 20 kills never exceed 256.
REQ-040 Kill all 8 -> CLEARED next cycle, xSpeed 0; after 90 SOF waveNum 1, SPAWN, mask 8'hFF, speed 64.
REQ-041 bottomReached with rightEdge on same SOF -> OVER, gameOver 1, no stepDown; later hits ignored.
REQ-042 resetN low mid-RUN with mask 8'h0F -> immediately SPAWN, mask 8'hFF, waveNum 0, outputs at reset values.
